load_trim_ctrl: RTL and testbench
=================================

# load_trim_ctrl

Load-path controller for the RV32I core. It accepts one load request at a time from the execute stage and issues a word-aligned read to data memory with an ack handshake. It selects the byte or halfword lane from the returned word and trims it with sign or zero extension. It returns the result to writeback through a valid/ready handshake. This block sequences and configures the load trimmer datapath; the trimmer is no longer driven directly from decode.

## Interface
- `MEM_TIMEOUT`, default 15: cycles in ISSUE without `mem_ack` before the load is aborted with an error; legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `req_valid` in 1: load request valid.
- `req_ready` out 1: block can accept a request.
- `req_addr` in 32: byte address.
- `req_funct3` in 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. All other codes are illegal.
- `mem_rd` out 1: memory read strobe, held until ack.
- `mem_addr` out 32: word-aligned address, with `[1:0]` always 00.
- `mem_rdata` in 32: read data, valid in the cycle `mem_ack`=1.
- `mem_ack` in 1: one-cycle read completion.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: writeback accepts the result.
- `rsp_data` out 32: trimmed and extended result.
- `rsp_err` out 1: qualifies `rsp_valid`; set for illegal funct3, misaligned access (when trapping is enabled) or timeout.
- `trim_width` out 2: current trim configuration. 0 = byte, 1 = half, 2 = word. Registered at accept.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid` with a legal, aligned request: latch `addr[1:0]`, funct3 and `trim_width`; drive `mem_addr`={addr[31:2],2'b00}; go to ISSUE.
  - On an illegal funct3: go to RESP with `rsp_err`=1 and `rsp_data`=0. No memory access is made.
- ISSUE:
  - `mem_rd`=1, `req_ready`=0. The timeout counter increments every cycle.
  - On `mem_ack`: capture the trimmed result and go to RESP.
  - If the counter reaches `MEM_TIMEOUT` without an ack: go to RESP with `rsp_err`=1 and `rsp_data`=0. Drop `mem_rd`.
- RESP:
  - `rsp_valid`=1. Data and error are held stable until `rsp_ready`=1, then go to IDLE.
- Lane selection is little-endian.
  - Byte lane = `addr[1:0]`: 0 selects `[7:0]`, 3 selects `[31:24]`.
  - Half lane = `addr[1]`: 0 selects `[15:0]`, 1 selects `[31:16]`.
- Extension:
  - LB and LH replicate the MSB of the selected lane.
  - LBU and LHU zero-fill.
  - LW passes `mem_rdata` unchanged.
- Alignment rules: LH requires `addr[0]`=0; LW requires `addr[1:0]`=00. Handling of violations is set by the macro below.
- A `mem_ack` outside ISSUE is ignored.
- Reset values: `req_ready`=0 during reset and 1 in the first cycle after; `mem_rd`=0, `mem_addr`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `trim_width`=2; FSM in IDLE; counter=0.

## Timing
- Accept at edge N. `mem_rd` is high from cycle N+1.
- With the ack in cycle N+1, `rsp_valid` rises in cycle N+2, giving a minimum latency of 2 cycles from accept to response.
- Timeout: `rsp_valid` with `rsp_err` rises exactly `MEM_TIMEOUT`+1 cycles after accept.
- Illegal or misaligned trap: `rsp_valid` at N+1. `mem_rd` never asserts.
- If `rsp_ready` is high in the first RESP cycle, `req_ready` is high in the next cycle. This gives a 3-cycle throughput per load with zero-wait memory.
- Reset asserted in any state: on the next edge the FSM is in IDLE and all outputs take their reset values. The in-flight load is lost and no response is produced.

## Configuration
- `MISALIGN_TRAP_EN` defined: a misaligned LH or LW is not issued. The FSM goes to RESP with `rsp_err`=1 and `rsp_data`=0.
- `MISALIGN_TRAP_EN` undefined:
  - The low address bits are forced aligned: LH uses `addr[1]` only, and LW ignores `addr[1:0]`.
  - The access proceeds normally with `rsp_err`=0.

## Test plan
- LBU, `req_addr`=0x101, `mem_rdata`=0x12348856, ack after 1 cycle -> `mem_addr`=0x100, `rsp_data`=0x00000088, `rsp_err`=0, and `rsp_valid` exactly 2 cycles after accept. Repeat as LB -> `rsp_data`=0xFFFFFF88.
- LH, addr 0x102, rdata 0x80001234 -> 0xFFFF8000. LHU at 0x100 -> 0x00001234. LW at 0x100 -> 0x80001234.
- `rsp_ready` held low for 5 cycles -> `rsp_valid`, `rsp_data` and `rsp_err` stay stable and `req_ready` stays 0. A second request presented during this time is not accepted until the cycle after `rsp_ready`=1.
- LW at 0x102: with `MISALIGN_TRAP_EN` -> `rsp_err`=1 in cycle N+1 and no `mem_rd`. Without the macro -> `mem_addr`=0x100 and the full word is returned.
- No ack with `MEM_TIMEOUT`=15 -> `mem_rd` high for 15 cycles, then `rsp_err`=1 and `rsp_data`=0. A late `mem_ack` in IDLE causes no response.
- funct3=011 -> error response in N+1 with no `mem_rd`. Separately, `rst_n`=0 while in ISSUE -> IDLE and all outputs at reset values on the next edge, with no spurious `rsp_valid`.

Source files
------------

// File: rtl/load_trim_ctrl.sv
// Load-path controller: accepts one RV32I load, issues a word read, trims/extends the lane.
// Optional macro MISALIGN_TRAP_EN: misaligned LH/LW return an error instead of being force-aligned.
module load_trim_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [1:0]  trim_width
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t      r_state;
  logic        r_req_ready;
  logic [1:0]  r_off;
  logic [2:0]  r_f3;
  logic [7:0]  r_cnt;

  logic        w_legal;
  logic        w_trap;
  logic [1:0]  w_width;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_trim;

  // Gated by rst_n so the block never advertises readiness while held in reset.
  assign req_ready = r_req_ready & rst_n;

  always_comb begin
    w_legal = 1'b1;
    w_width = 2'd2;
    case (req_funct3)
      F3_LB, F3_LBU: w_width = 2'd0;
      F3_LH, F3_LHU: w_width = 2'd1;
      F3_LW:         w_width = 2'd2;
      default:       w_legal = 1'b0;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic w_misal;
  assign w_misal = ((w_width == 2'd1) && req_addr[0]) ||
                   ((w_width == 2'd2) && (req_addr[1:0] != 2'b00));
  assign w_trap  = w_misal;
`else
  // Force-aligned: half lane uses addr[1] only, word ignores the low bits.
  assign w_trap  = 1'b0;
`endif

  // Little-endian lane select from the latched offset.
  assign w_byte = mem_rdata[{r_off, 3'b000} +: 8];
  assign w_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    w_trim = mem_rdata;
    case (r_f3)
      F3_LB:   w_trim = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  w_trim = {24'b0, w_byte};
      F3_LH:   w_trim = {{16{w_half[15]}}, w_half};
      F3_LHU:  w_trim = {16'b0, w_half};
      default: w_trim = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_off       <= 2'b00;
      r_f3        <= 3'b000;
      r_cnt       <= 8'd0;
      mem_rd      <= 1'b0;
      mem_addr    <= 32'd0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 32'd0;
      rsp_err     <= 1'b0;
      trim_width  <= 2'd2;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_req_ready <= 1'b0;
            if (!w_legal || w_trap) begin
              if (w_legal) trim_width <= w_width;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= 32'd0;
              r_state   <= S_RESP;
            end else begin
              r_off      <= req_addr[1:0];
              r_f3       <= req_funct3;
              trim_width <= w_width;
              mem_addr   <= {req_addr[31:2], 2'b00};
              mem_rd     <= 1'b1;
              r_cnt      <= 8'd0;
              r_state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          // An ack arriving on the timeout cycle still wins.
          if (mem_ack) begin
            mem_rd    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= w_trim;
            r_state   <= S_RESP;
          end else if (r_cnt == CNT_LAST) begin
            mem_rd    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= 32'd0;
            r_state   <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          mem_rd      <= 1'b0;
          rsp_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_trim_ctrl.sv
// Scoreboard bench for load_trim_ctrl: expected responses queued at accept, popped on handshake.
module tb_load_trim_ctrl;

  localparam int T = 15;
  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, mem_rd, mem_ack, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, mem_addr, mem_rdata, rsp_data;
  logic [2:0]  req_funct3;
  logic [1:0]  trim_width;

  typedef struct packed { logic err; logic [31:0] data; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  load_trim_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_funct3(req_funct3), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .trim_width(trim_width)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) chk("rsp_unexp", {31'b0, rsp_valid}, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("rsp_data", rsp_data, mon_e.data);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end
  end

  // ack_dly: ISSUE cycles before the ack (0 = ack in N+1), negative = never ack.
  task automatic ld(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] rd,
                    input int ack_dly, input logic [31:0] ed, input logic ee,
                    input logic mem, input int tw);
    int lat, nrd, elat, enrd;
    chk("req_ready_pre", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_addr = a; req_funct3 = f3; mem_rdata = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back({ee, ed});
    if (tw >= 0) chk("trim_width", {30'b0, trim_width}, 32'(tw));
    if (mem) chk("mem_addr", mem_addr, {a[31:2], 2'b00});
    lat = 1; nrd = 0;
    while (!rsp_valid && lat < 40) begin
      if (mem_rd) nrd++;
      mem_ack = (lat - 1 == ack_dly);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      lat++;
    end
    elat = !mem ? 1 : (ack_dly >= 0 ? ack_dly + 2 : T + 1);
    enrd = !mem ? 0 : (ack_dly >= 0 ? ack_dly + 1 : T);
    chk("latency", 32'(lat), 32'(elat));
    chk("mem_rd_cycles", 32'(nrd), 32'(enrd));
    if (rsp_ready) begin
      @(posedge clk); #1;
      chk("req_ready_post", {31'b0, req_ready}, 32'd1);
      chk("rsp_valid_drop", {31'b0, rsp_valid}, 32'd0);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
    chk({tag, "_mem_rd"}, {31'b0, mem_rd}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_rsp_err"}, {31'b0, rsp_err}, 32'd0);
    chk({tag, "_trim_width"}, {30'b0, trim_width}, 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
    mem_rdata = '0; mem_ack = 1'b0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_rst", {31'b0, req_ready}, 32'd1);

    ld(32'h101, LBU, 32'h12348856, 0, 32'h00000088, 1'b0, 1'b1, 0);
    ld(32'h101, LB,  32'h12348856, 0, 32'hFFFFFF88, 1'b0, 1'b1, 0);
    ld(32'h102, LH,  32'h80001234, 0, 32'hFFFF8000, 1'b0, 1'b1, 1);
    ld(32'h100, LHU, 32'h80001234, 0, 32'h00001234, 1'b0, 1'b1, 1);
    ld(32'h100, LW,  32'h80001234, 0, 32'h80001234, 1'b0, 1'b1, 2);
    ld(32'h103, LBU, 32'hA5000000, 3, 32'h000000A5, 1'b0, 1'b1, 0);
    ld(32'h200, LB,  32'h0000007F, 1, 32'h0000007F, 1'b0, 1'b1, 0);
    ld(32'h202, LHU, 32'hF00D0000, 2, 32'h0000F00D, 1'b0, 1'b1, 1);

`ifdef MISALIGN_TRAP_EN
    ld(32'h102, LW, 32'h80001234, 0, 32'h00000000, 1'b1, 1'b0, 2);
    ld(32'h101, LH, 32'h80001234, 0, 32'h00000000, 1'b1, 1'b0, 1);
`else
    ld(32'h102, LW, 32'h80001234, 0, 32'h80001234, 1'b0, 1'b1, 2);
    ld(32'h101, LH, 32'h80001234, 0, 32'h00001234, 1'b0, 1'b1, 1);
`endif

    // Timeout then a stray ack in IDLE.
    ld(32'h400, LW, 32'hDEADBEEF, -1, 32'h00000000, 1'b1, 1'b1, 2);
    mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack_no_rsp", {31'b0, rsp_valid}, 32'd0);
      chk("late_ack_mem_rd", {31'b0, mem_rd}, 32'd0);
      @(posedge clk); #1;
    end

    ld(32'h100, 3'b011, 32'h11111111, 0, 32'h00000000, 1'b1, 1'b0, -1);
    ld(32'h100, 3'b111, 32'h11111111, 0, 32'h00000000, 1'b1, 1'b0, -1);

    // Backpressure: response held, a second request waits.
    rsp_ready = 1'b0;
    ld(32'h101, LBU, 32'h12348856, 0, 32'h00000088, 1'b0, 1'b1, 0);
    req_valid = 1'b1; req_addr = 32'h101; req_funct3 = LB;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("bp_rsp_data", rsp_data, 32'h00000088);
      chk("bp_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
      chk("bp_mem_rd", {31'b0, mem_rd}, 32'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    chk("bp_req_ready_rel", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("bp_idle_mem_rd", {31'b0, mem_rd}, 32'd0);
    ld(32'h101, LB, 32'h12348856, 0, 32'hFFFFFF88, 1'b0, 1'b1, 0);

    // Reset while in ISSUE: load is dropped silently.
    req_valid = 1'b1; req_addr = 32'h300; req_funct3 = LW;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("issue_mem_rd", {31'b0, mem_rd}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_outs("mid_rst");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_mid_rst", {31'b0, req_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("no_spurious_rsp", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    ld(32'h100, LHU, 32'h80001234, 0, 32'h00001234, 1'b0, 1'b1, 1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
